ikascc_primitive_mchdncntr: RTL and testbench

Parametrised multi-channel down-counter bank, the successor to the single-channel down-counter primitive. It provides CH independent W-bit counters, each with its own reload register, count enable and mode (auto-reload or one-shot). Each channel raises a registered one-enable-cycle borrow pulse at terminal count. It sits under the SCC frequency, envelope and timer logic, which currently instantiates one counter per channel and drives the reload data externally.

---
 rtl/ikascc_primitive_mchdncntr.sv | 112 +++++++++++
 tb/tb_ikascc_primitive_mchdncntr.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ikascc_primitive_mchdncntr.sv
// Multi-channel down-counter bank: CH independent W-bit counters, each with its
// own reload register, auto-reload/one-shot mode and a registered borrow pulse.

module ikascc_primitive_mchdncntr_lane #(
  parameter int W = 12
) (
  input  logic         i_EMUCLK,
  input  logic         i_RST,
  input  logic         i_MCLK_PCEN_n,
  input  logic         i_WR_HIT,
  input  logic [W-1:0] i_WDATA,
  input  logic         i_LD,
  input  logic         i_CNT,
  input  logic         i_MODE,
  output logic [W-1:0] o_Q,
  output logic         o_BO,
  output logic         o_RUN
);
  logic [W-1:0] cntr_q, cntr_d, rld_q, rld_d, eff_rld;
  logic         run_q, run_d, bo_q, bo_d;

  // Write-through: a same-edge write to this channel is what LD/reload sees.
  assign eff_rld = i_WR_HIT ? i_WDATA : rld_q;

  always_comb begin
    cntr_d = cntr_q;
    rld_d  = rld_q;
    run_d  = run_q;
    bo_d   = bo_q;
    if (!i_MCLK_PCEN_n) begin
      bo_d = 1'b0;
      if (i_WR_HIT) rld_d = i_WDATA;
      if (i_LD) begin
        cntr_d = eff_rld;
        run_d  = 1'b1;
      end else if (i_CNT && run_q) begin
        if (cntr_q != '0) begin
          cntr_d = cntr_q - W'(1);
        end else begin
          // Terminal count replaces underflow: reload or stop, never wrap.
          bo_d = 1'b1;
          if (i_MODE) cntr_d = eff_rld;
          else        run_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      cntr_q <= '1;
      rld_q  <= '1;
      run_q  <= 1'b0;
      bo_q   <= 1'b0;
    end else begin
      cntr_q <= cntr_d;
      rld_q  <= rld_d;
      run_q  <= run_d;
      bo_q   <= bo_d;
    end
  end

  assign o_Q   = cntr_q;
  assign o_BO  = bo_q;
  assign o_RUN = run_q;
endmodule

module ikascc_primitive_mchdncntr #(
  parameter int W  = 12,
  parameter int CH = 5,
  parameter int AW = 3
) (
  input  logic            i_EMUCLK,
  input  logic            i_RST,
  input  logic            i_MCLK_PCEN_n,
  input  logic            i_WR,
  input  logic [AW-1:0]   i_WADDR,
  input  logic [W-1:0]    i_WDATA,
  input  logic [CH-1:0]   i_LD,
  input  logic [CH-1:0]   i_CNT,
  input  logic [CH-1:0]   i_MODE,
  output logic [CH*W-1:0] o_Q,
  output logic [CH-1:0]   o_ZERO,
  output logic [CH-1:0]   o_BO,
  output logic [CH-1:0]   o_RUN
);
  logic [CH-1:0]        wr_hit;
  logic [CH-1:0][W-1:0] q;

  // Addresses >= CH match no lane, so out-of-range writes drop naturally.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    assign wr_hit[k] = i_WR && (i_WADDR == AW'(k));

    ikascc_primitive_mchdncntr_lane #(.W(W)) u_lane (
      .i_EMUCLK      (i_EMUCLK),
      .i_RST         (i_RST),
      .i_MCLK_PCEN_n (i_MCLK_PCEN_n),
      .i_WR_HIT      (wr_hit[k]),
      .i_WDATA       (i_WDATA),
      .i_LD          (i_LD[k]),
      .i_CNT         (i_CNT[k]),
      .i_MODE        (i_MODE[k]),
      .o_Q           (q[k]),
      .o_BO          (o_BO[k]),
      .o_RUN         (o_RUN[k])
    );

    assign o_ZERO[k] = (q[k] == '0);
  end

  assign o_Q = q;
endmodule

// File: tb/tb_ikascc_primitive_mchdncntr.sv
// Directed bench for the multi-channel down-counter bank (W=12, CH=5, AW=3).

module tb_ikascc_primitive_mchdncntr;
  localparam int W  = 12;
  localparam int CH = 5;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst, pcen_n, wr;
  logic [AW-1:0]   waddr;
  logic [W-1:0]    wdata;
  logic [CH-1:0]   ld, cnt, mode;
  logic [CH*W-1:0] o_q;
  logic [CH-1:0]   o_zero, o_bo, o_run;

  int checks   = 0;
  int failures = 0;

  ikascc_primitive_mchdncntr #(.W(W), .CH(CH), .AW(AW)) dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_MCLK_PCEN_n (pcen_n),
    .i_WR          (wr),
    .i_WADDR       (waddr),
    .i_WDATA       (wdata),
    .i_LD          (ld),
    .i_CNT         (cnt),
    .i_MODE        (mode),
    .o_Q           (o_q),
    .o_ZERO        (o_zero),
    .o_BO          (o_bo),
    .o_RUN         (o_run)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] qch(input int k);
    return o_q[k*W +: W];
  endfunction

  localparam logic [CH*W-1:0] Q_RST = '1;

  // ch0 auto-reload, rld=3: values after each counted edge
  logic [W-1:0] exp_auto [8] = '{12'd2, 12'd1, 12'd0, 12'd3, 12'd2, 12'd1, 12'd0, 12'd3};
  logic         bo_auto  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  // ch0 with enable toggling: even steps enabled, odd steps disabled
  logic [W-1:0] exp_tog  [8] = '{12'd2, 12'd2, 12'd1, 12'd1, 12'd0, 12'd0, 12'd3, 12'd3};
  logic         bo_tog   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; pcen_n = 1'b0; wr = 1'b0; waddr = '0; wdata = '0;
    ld = '0; cnt = '0; mode = '0;
    tick();
    rst = 1'b0;
    chk("rst_q",    64'(o_q),    64'(Q_RST));
    chk("rst_zero", 64'(o_zero), 64'(0));
    chk("rst_bo",   64'(o_bo),   64'(0));
    chk("rst_run",  64'(o_run),  64'(0));

    // Disabled edges: LD and CNT must not move anything
    pcen_n = 1'b1; ld = '1; cnt = '1;
    repeat (3) tick();
    chk("dis_q",   64'(o_q),   64'(Q_RST));
    chk("dis_run", 64'(o_run), 64'(0));

    // CNT without LD on stopped channels is ignored
    pcen_n = 1'b0; ld = '0;
    repeat (10) tick();
    chk("cnt_nold_q",  64'(o_q),  64'(Q_RST));
    chk("cnt_nold_bo", 64'(o_bo), 64'(0));
    cnt = '0;

    // ch0 auto-reload with rld=3
    wr = 1'b1; waddr = 3'd0; wdata = 12'd3;
    tick();
    wr = 1'b0; ld[0] = 1'b1; mode[0] = 1'b1;
    tick();
    chk("auto_ld_q",   64'(qch(0)),   64'(3));
    chk("auto_ld_run", 64'(o_run[0]), 64'(1));
    ld = '0; cnt[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("auto_q%0d", i),  64'(qch(0)),    64'(exp_auto[i]));
      chk($sformatf("auto_bo%0d", i), 64'(o_bo[0]),   64'(bo_auto[i]));
      chk($sformatf("auto_z%0d", i),  64'(o_zero[0]), 64'(exp_auto[i] == 0));
    end
    cnt[0] = 1'b0;
    tick();
    chk("auto_hold_q",  64'(qch(0)),  64'(3));
    chk("auto_hold_bo", 64'(o_bo[0]), 64'(0));

    // ch1 one-shot with rld=2
    wr = 1'b1; waddr = 3'd1; wdata = 12'd2;
    tick();
    wr = 1'b0; ld[1] = 1'b1;
    tick();
    chk("os_ld_q", 64'(qch(1)), 64'(2));
    ld = '0; cnt[1] = 1'b1;
    tick(); chk("os_q1", 64'(qch(1)), 64'(1));
    tick(); chk("os_q0", 64'(qch(1)), 64'(0));
    chk("os_bo_pre", 64'(o_bo[1]), 64'(0));
    tick();
    chk("os_tc_q",   64'(qch(1)),   64'(0));
    chk("os_tc_bo",  64'(o_bo[1]),  64'(1));
    chk("os_tc_run", 64'(o_run[1]), 64'(0));
    tick();
    chk("os_after_bo", 64'(o_bo[1]), 64'(0));
    tick();
    chk("os_stay_q", 64'(qch(1)),   64'(0));
    chk("os_stay_z", 64'(o_zero[1]), 64'(1));
    cnt = '0;

    // ch0 terminal count while the enable toggles every edge
    cnt[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pcen_n = i[0];
      tick();
      chk($sformatf("tog_q%0d", i),  64'(qch(0)),  64'(exp_tog[i]));
      chk($sformatf("tog_bo%0d", i), 64'(o_bo[0]), 64'(bo_tog[i]));
    end
    pcen_n = 1'b0;
    tick();
    chk("tog_end_q",  64'(qch(0)),  64'(2));
    chk("tog_end_bo", 64'(o_bo[0]), 64'(0));
    cnt = '0;

    // Write-through on ch2, then an out-of-range write, then load everything
    wr = 1'b1; waddr = 3'd2; wdata = 12'd7; ld[2] = 1'b1;
    tick();
    chk("wt_q2",   64'(qch(2)),   64'(7));
    chk("wt_run2", 64'(o_run[2]), 64'(1));
    waddr = 3'd7; wdata = 12'd5; ld = '0;
    tick();
    wr = 1'b0; ld = '1;
    tick();
    chk("oor_q", 64'(o_q), {12'hFFF, 12'hFFF, 12'd7, 12'd2, 12'd3});
    ld = '0;

    // Reload 0 in auto mode borrows on every counted edge
    wr = 1'b1; waddr = 3'd3; wdata = 12'd0; ld[3] = 1'b1; mode[3] = 1'b1;
    tick();
    chk("r0_ld_q",  64'(qch(3)),  64'(0));
    chk("r0_ld_bo", 64'(o_bo[3]), 64'(0));
    wr = 1'b0; ld = '0; cnt[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("r0_bo%0d", i), 64'(o_bo[3]), 64'(1));
      chk($sformatf("r0_q%0d", i),  64'(qch(3)),  64'(0));
    end

    // Reset mid-count with LD, CNT and WR all asserted
    cnt = '1; mode = '1;
    repeat (2) tick();
    rst = 1'b1; ld = '1; wr = 1'b1; waddr = 3'd0; wdata = 12'd9;
    tick();
    chk("mrst_q",    64'(o_q),    64'(Q_RST));
    chk("mrst_zero", 64'(o_zero), 64'(0));
    chk("mrst_bo",   64'(o_bo),   64'(0));
    chk("mrst_run",  64'(o_run),  64'(0));
    rst = 1'b0; ld = '0; wr = 1'b0; cnt = '0;
    ld[0] = 1'b1;
    tick();
    chk("mrst_rld_q",   64'(qch(0)),   64'(12'hFFF));
    chk("mrst_rld_run", 64'(o_run[0]), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
